template_match_sad: RTL

- Downstream consumer of the line buffer's 40x100 binary window vector.
- For each presented window position, computes the sum of absolute differences (SAD) between the window and a stored 40x100 binary template. This equals the popcount of the XOR.
- Evaluates one row per cycle and tracks the minimum-SAD position across a frame.
- On frame end, reports the best-match coordinates and score to the result/overlay logic.

---
 rtl/template_match_sad.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/template_match_sad.sv
// template_match_sad: row-serial SAD (popcount of XOR) between a binary
// 40x100 window and a stored template, tracking the minimum-SAD window
// position across a frame and reporting it when the frame ends.
module template_match_sad #(
    parameter int unsigned W    = 40,
    parameter int unsigned H    = 100,
    parameter int unsigned XW   = 10,
    parameter int unsigned YW   = 9,
    parameter int unsigned SADW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W*H-1:0]    win_in,
    input  logic [XW-1:0]     win_x,
    input  logic [YW-1:0]     win_y,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [W*H-1:0]    tmpl_in,
    input  logic              frame_end,
    output logic [XW-1:0]     best_x,
    output logic [YW-1:0]     best_y,
    output logic [SADW-1:0]   best_sad,
    output logic              found,
    output logic              result_valid
);

    localparam int unsigned N  = W * H;
    localparam int unsigned RW = $clog2(H);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_q, state_n;

    // Latched window and its coordinates
    logic [N-1:0]    win_q,   win_n;
    logic [XW-1:0]   wx_q,    wx_n;
    logic [YW-1:0]   wy_q,    wy_n;
    // Row-serial accumulation
    logic [RW-1:0]   row_q,   row_n;
    logic [SADW-1:0] acc_q,   acc_n;
    // Running frame best
    logic            have_q,  have_n;
    logic [SADW-1:0] bsad_q,  bsad_n;
    logic [XW-1:0]   bx_q,    bx_n;
    logic [YW-1:0]   by_q,    by_n;
    logic            pend_q,  pend_n;
    // Registered result outputs
    logic [XW-1:0]   obx_n;
    logic [YW-1:0]   oby_n;
    logic [SADW-1:0] obsad_n;
    logic            ofound_n;
    logic            orv_n;

    logic            xfer;
    logic            last_row;
    logic [IW-1:0]   base;
    logic [W-1:0]    win_row;
    logic [W-1:0]    tmpl_row;
    logic            better;

    // Number of set bits in one row, zero-extended to the accumulator width
    function automatic logic [SADW-1:0] popcount(input logic [W-1:0] v);
        logic [SADW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(W); i++) begin
            n = n + SADW'(v[i]);
        end
        return n;
    endfunction

    // Ready only while idle with no frame finalisation outstanding
    assign win_ready = !rst && (state_q == IDLE) && !pend_q;
    assign xfer      = win_valid && win_ready;
    assign last_row  = (row_q == RW'(H - 1));
    assign base      = IW'(row_q) * IW'(W);
    assign win_row   = win_q[base +: W];
    assign tmpl_row  = tmpl_in[base +: W];
    assign better    = !have_q || (acc_q < bsad_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_n = ACCUM;
                end else if (pend_q) begin
                    state_n = DONE;
                end
            end
            ACCUM: begin
                if (last_row) begin
                    state_n = COMPARE;
                end
            end
            COMPARE: begin
                state_n = pend_q ? DONE : IDLE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        win_n    = win_q;
        wx_n     = wx_q;
        wy_n     = wy_q;
        row_n    = row_q;
        acc_n    = acc_q;
        have_n   = have_q;
        bsad_n   = bsad_q;
        bx_n     = bx_q;
        by_n     = by_q;
        pend_n   = pend_q | frame_end;
        obx_n    = best_x;
        oby_n    = best_y;
        obsad_n  = best_sad;
        ofound_n = found;
        orv_n    = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    win_n = win_in;
                    wx_n  = win_x;
                    wy_n  = win_y;
                    acc_n = '0;
                    row_n = '0;
                end
            end
            ACCUM: begin
                acc_n = acc_q + popcount(win_row ^ tmpl_row);
                row_n = last_row ? '0 : row_q + RW'(1);
            end
            COMPARE: begin
                // Strict less-than: ties keep the earlier window
                if (better) begin
                    bsad_n = acc_q;
                    bx_n   = wx_q;
                    by_n   = wy_q;
                    have_n = 1'b1;
                end
            end
            DONE: begin
                have_n = 1'b0;
                bsad_n = '1;
                bx_n   = '0;
                by_n   = '0;
                pend_n = 1'b0;
            end
            default: begin
            end
        endcase

        // Load the outputs on entry to DONE so they are valid with the strobe
        if (state_n == DONE) begin
            orv_n    = 1'b1;
            obx_n    = bx_n;
            oby_n    = by_n;
            obsad_n  = bsad_n;
            ofound_n = have_n;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q        <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            have_q       <= 1'b0;
            bsad_q       <= '1;
            bx_q         <= '0;
            by_q         <= '0;
            pend_q       <= 1'b0;
            best_x       <= '0;
            best_y       <= '0;
            best_sad     <= '1;
            found        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            win_q        <= win_n;
            wx_q         <= wx_n;
            wy_q         <= wy_n;
            row_q        <= row_n;
            acc_q        <= acc_n;
            have_q       <= have_n;
            bsad_q       <= bsad_n;
            bx_q         <= bx_n;
            by_q         <= by_n;
            pend_q       <= pend_n;
            best_x       <= obx_n;
            best_y       <= oby_n;
            best_sad     <= obsad_n;
            found        <= ofound_n;
            result_valid <= orv_n;
        end
    end

endmodule
